// File: rtl/ins_prefetch.sv
// Instruction prefetch buffer: streams sequential words ahead of the core into a
// small in-order FIFO, serves same-cycle hits, and flushes on non-sequential requests.
module ins_prefetch #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        exIns_ren,
  input  logic [31:0] exIns_addr,
  output logic        exIns_valid,
  output logic [31:0] exIns_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_OUT + 1);
  localparam int SW = CW + IW + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_head_addr;
  logic [31:0]   r_fifo [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_inflight;
  logic [IW-1:0] r_drop_cnt;

  logic [31:0]   w_addr;
  logic          w_run;
  logic          w_match;
  logic          w_flush;
  logic          w_rsp;
  logic          w_keep;
  logic          w_empty;
  logic          w_bypass;
  logic          w_pop;
  logic          w_hit;
  logic          w_push;
  logic [SW-1:0] w_credit;
  logic          w_req;
  logic          w_gnt;

  assign w_addr   = {exIns_addr[31:2], 2'b00};
  assign w_run    = (r_state == S_RUN);
  assign w_match  = w_run & exIns_ren & (w_addr == r_head_addr);
  assign w_flush  = w_run & exIns_ren & (w_addr != r_head_addr);

  // Responses with nothing outstanding (e.g. from before reset) are ignored.
  assign w_rsp    = mem_rvalid & (r_inflight != '0);
  assign w_keep   = w_rsp & (r_drop_cnt == '0) & ~w_flush;
  assign w_empty  = (r_count == '0);
  assign w_bypass = w_match & w_empty & w_keep;
  assign w_pop    = w_match & ~w_empty;
  assign w_hit    = w_pop | w_bypass;
  assign w_push   = w_keep & ~w_bypass;

  // Live requests (not destined to be dropped) reserve a FIFO slot, so it never overflows.
  assign w_credit = SW'(r_count) + SW'(r_inflight) - SW'(r_drop_cnt);
  assign w_req    = w_run & ~w_flush & (r_inflight < IW'(MAX_OUT)) & (w_credit < SW'(DEPTH));
  assign w_gnt    = w_req & mem_gnt;

  assign exIns_valid = w_hit;
  assign exIns_in    = w_pop ? r_fifo[r_rptr] : (w_bypass ? mem_rdata : 32'd0);
  assign mem_req     = w_req;
  assign mem_addr    = r_fetch_addr;

  // Data storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state      <= S_IDLE;
      r_fetch_addr <= 32'd0;
      r_head_addr  <= 32'd0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_inflight   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (exIns_ren) begin
            r_state      <= S_RUN;
            r_fetch_addr <= w_addr;
            r_head_addr  <= w_addr;
          end
        end
        S_RUN: begin
          if (w_flush) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            r_fetch_addr <= w_addr;
            r_head_addr  <= w_addr;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_inflight   <= r_inflight - IW'(w_rsp);
            r_drop_cnt   <= r_inflight - IW'(w_rsp);
          end else begin
            if (w_gnt) begin
              r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            if (w_hit) begin
              r_head_addr <= r_head_addr + 32'd4;
            end
            if (w_push) begin
              r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
              r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
              r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
              r_count <= r_count - CW'(1);
            end
            r_inflight <= r_inflight + IW'(w_gnt) - IW'(w_rsp);
            if (w_rsp && (r_drop_cnt != '0)) begin
              r_drop_cnt <= r_drop_cnt - IW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ins_prefetch.md
# ins_prefetch

Instruction prefetch buffer between the core's external instruction port (`exIns_ren`/`exIns_addr`/`exIns_valid`/`exIns_in`) and the instruction memory bus. It fetches sequential 32-bit words ahead of the core into a small in-order FIFO and serves hits the same cycle. A non-sequential request (branch target) flushes the stream; in-flight memory responses for the old stream are discarded.

## Interface
- `DEPTH`, 4: buffer entries; power of two, ≥2.
- `MAX_OUT`, 2: max memory requests in flight; 1..DEPTH.
- `clk` input 1: clock, all state on rising edge.
- `nrst` input 1: synchronous, active-high reset (1 = reset, sampled on `clk`).
- `exIns_ren` input 1: core requests the instruction at `exIns_addr`.
- `exIns_addr` input 32: word address; bits [1:0] ignored, treated as 0.
- `exIns_valid` output 1: `exIns_in` holds the instruction for `exIns_addr` this cycle.
- `exIns_in` output 32: instruction word; 0 when `exIns_valid`=0.
- `mem_req` output 1: read request.
- `mem_addr` output 32: request address, [1:0]=0.
- `mem_gnt` input 1: request accepted; sampled only when `mem_req`=1.
- `mem_rvalid` input 1: read data returned; in-order, ≥1 cycle after its grant.
- `mem_rdata` input 32: read data.

## Operation
- State regs: `state` {IDLE, RUN}, `fetch_addr`, `head_addr`, FIFO (`count` 0..DEPTH), `inflight` 0..MAX_OUT, `drop_cnt` 0..inflight.
- IDLE (after reset): `mem_req`=0, `exIns_valid`=0. On `exIns_ren`: `fetch_addr`,`head_addr` <= `exIns_addr`; go to RUN.
- RUN:
  - Hit: `exIns_ren` and `exIns_addr`==`head_addr` and (`count`>0, or `count`==0 with `mem_rvalid` and `drop_cnt`==0, the bypass case). Drive `exIns_valid`=1 and `exIns_in`=head/bypass data, pop, `head_addr` += 4.
  - Wait: address matches but no data. `exIns_valid`=0 and no state change except normal fetch.
  - Miss/flush: `exIns_ren` and `exIns_addr`!=`head_addr`.
    - `count`<=0; `fetch_addr`,`head_addr` <= `exIns_addr`.
    - `drop_cnt` <= `inflight` − (`mem_rvalid` this cycle).
    - `mem_req` forced 0 this cycle; any `mem_rvalid` this cycle is discarded.
- Issue rule: `mem_req`=1 iff RUN, no flush this cycle, `inflight`<MAX_OUT and `count`+(`inflight`−`drop_cnt`)<DEPTH. `mem_addr`=`fetch_addr`. On `mem_req`&`mem_gnt`: `fetch_addr` += 4 and `inflight`++.
- Response rule: on `mem_rvalid` with `inflight`>0: `inflight`--. If `drop_cnt`>0, the word is discarded and `drop_cnt`--. Otherwise it is pushed, unless consumed by bypass. A `mem_rvalid` with `inflight`==0 is ignored.
- Push and pop in the same cycle leave `count` unchanged. The credit rule makes overflow impossible; no full-drop path exists.
- Address arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000 for both `fetch_addr` and `head_addr`.
- No return to IDLE except by reset.

## Timing
- Reset values: `state`=IDLE, `mem_req`=0, `mem_addr`=0, `exIns_valid`=0, `exIns_in`=0, `count`=`inflight`=`drop_cnt`=0, `fetch_addr`=`head_addr`=0.
- Reset mid-operation clears all state the next edge. Responses from before reset are ignored via the `inflight`==0 rule.
- `exIns_valid`/`exIns_in` are combinational from the core inputs, FIFO head and the bypass path. `mem_req` is combinational from state and the flush compare.
- Miss at cycle t → `mem_req` at t+1. With `mem_gnt` at t+1 and `mem_rvalid` at t+2, `exIns_valid` is at t+2 via bypass, giving a 2-cycle miss penalty at minimum memory latency.
- Sequential stream with memory granting every cycle at 1-cycle latency: 1 instruction/cycle sustained.
- Simultaneous flush + `mem_rvalid`: data dropped, counted against `inflight` (not `drop_cnt`). Simultaneous flush with `drop_cnt`>0: the new `drop_cnt` covers all remaining in-flight requests.

## Test plan
- Cold start: reset, then `exIns_ren` at 0x100. Mem grants at once, 1-cycle latency, data = addr. Required: `mem_addr` sequence 0x100,0x104,…; core receives 0x100 two cycles after request; then one instruction per cycle, 0x104, 0x108….
- Fill: core holds `exIns_ren`=0 after the first hit. Required: exactly DEPTH words buffered, then `mem_req`=0. Resuming gives DEPTH consecutive same-cycle hits.
- Branch with in-flight: memory latency 3, MAX_OUT=2, two requests granted. Core jumps to 0x400. Required: 2 responses discarded, first delivered word is 0x400's data, `mem_addr` restarts at 0x400.
- Flush coincident with `mem_rvalid` and `mem_gnt`=1. Required: no `mem_req` in the flush cycle, returned word never delivered, `inflight`/`drop_cnt` consistent (no extra drop).
- Wrap: branch to 0xFFFF_FFF8. Required: `mem_addr` 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; sequential hits continue across the wrap.
- Reset with buffer full and 2 in flight, then stale `mem_rvalid`. Required: all outputs at reset values, stale data ignored, IDLE until next `exIns_ren`.
